serial_frame_tx: RTL



---
 rtl/serial_frame_pkg.sv | 17 +
 rtl/bit_tick_counter.sv | 30 +++
 rtl/serial_frame_tx.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the framed serial transmitter.
// The state encoding and the fixed start/stop/idle levels live here so the capture side can import them too.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
// Held at zero while clear is high, so the first bit after clear gets its full length.
module bit_tick_counter #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cyc_cnt;

  // With BIT_CYCLES=1 the count never leaves zero and tick stays high.
  assign tick = (cyc_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (clear || tick) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// One word is accepted per frame through a valid/ready handshake; every output is a flop.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              parity;
  logic [IDX_W-1:0]  bit_idx;
  logic              tick;
  logic              clear;

  assign clear      = (state == IDLE);
  assign shreg_next = shreg >> 1;

  bit_tick_counter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );

  // NOTE: all FSM state and outputs use non-blocking assignments; the async reset
  // forces tx_out back to the idle level at once, discarding any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      parity   <= 1'b0;
      bit_idx  <= '0;
      tx_out   <= LINE_IDLE;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            parity   <= ^tx_data;
            state    <= START;
            tx_out   <= START_BIT;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_out  <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state  <= PARITY;
                tx_out <= parity;
              end else begin
                state  <= STOP;
                tx_out <= STOP_BIT;
              end
            end else begin
              // Line shows the next bit as the shift happens, so each bit gets a full period.
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg_next;
              tx_out  <= shreg_next[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state  <= STOP;
            tx_out <= STOP_BIT;
          end
        end
        STOP: begin
          if (tick) begin
            state    <= IDLE;
            tx_out   <= LINE_IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
